pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have: Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
REQ-004 SHALL have: Rs1E, Rs2E, RdE  in  5 each  sources and destination of the instruction in Execute.
REQ-005 SHALL have: ResultSrcE  in  2  2'b01 = Execute instruction is a load.
REQ-006 SHALL have: PCSrcE  in  1  branch taken or jump in Execute.
REQ-007 SHALL have: RdM, RdW  in  5 each; RegWriteM, RegWriteW  in  1 each  Memory and Writeback destination and write enable.
REQ-008 SHALL have: MemReqM  in  1 (load/store in Memory); MemReadyM  in  1 (data bus ready).
REQ-009 SHALL have: StallF, StallD, StallE, StallM, FlushD, FlushE  out  1 each  pipeline-register controls.
REQ-010 SHALL have: ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 = register file, 01 = Writeback, 10 = Memory.
REQ-011 SHALL have: BusTimeout  out  1  sticky data-bus timeout flag.

Function
REQ-012 ForwardAE SHALL be 10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00; combinational, zero latency. ForwardBE SHALL use the same rule with Rs2E.
REQ-013 lwStall SHALL be ResultSrcE==01 and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
REQ-014 memStall SHALL be 1 when MemReqM=1, MemReadyM=0 and FSM is not ABORT.
REQ-015 If memStall=1: StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0, because flush overrides stall in the stage registers. This case SHALL have the highest priority.
REQ-016 Else if PCSrcE=1: FlushD=FlushE=1 and all stalls 0. This case SHALL win over a simultaneous lwStall.
REQ-017 Else if lwStall=1: StallF=StallD=1 and FlushE=1 (one bubble); StallE=StallM=0.
REQ-018 Otherwise all stall and flush outputs SHALL be 0.
REQ-019 The wait FSM SHALL have the states IDLE, WAIT and ABORT.
REQ-020 FSM transitions SHALL be: IDLE to WAIT on memStall; WAIT to IDLE on MemReadyM=1; WAIT to ABORT when WaitCnt==255 and MemReadyM=0; ABORT to IDLE unconditionally after one cycle.
REQ-021 WaitCnt SHALL be an 8-bit counter: cleared in IDLE, incremented each cycle in WAIT, never wrapping.
REQ-022 In ABORT, memStall SHALL be 0 so the stalled access retires and the pipeline releases; BusTimeout SHALL be set on entry to ABORT and held until reset.
REQ-023 MemReadyM=1 in the same cycle WaitCnt reaches 255 SHALL go to IDLE with no timeout.
REQ-024 A new MemReqM in the cycle after ABORT SHALL be treated as a fresh access from IDLE.

Reset
REQ-025 rst=1 SHALL immediately force the FSM to IDLE, WaitCnt=0 and BusTimeout=0, regardless of clk.
REQ-026 While rst=1, outputs SHALL be the combinational result of the REQ-012 to REQ-018 rules with the FSM in IDLE.
REQ-027 Reset asserted mid-WAIT SHALL abandon the wait with no timeout recorded.

Configuration
REQ-028 With HAZ_PERF_CNT_EN defined, the block SHALL add outputs StallCycCnt[31:0] and FlushCnt[31:0], both reset to 0 and wrapping at 2^32. StallCycCnt SHALL count cycles with StallF=1. FlushCnt SHALL count cycles with FlushE=1.
REQ-029 Without HAZ_PERF_CNT_EN, these ports and counters SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-030 Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 instead -> ForwardAE=01.
REQ-031 ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=1, FlushE=1 for exactly one cycle once RdE changes.
REQ-032 PCSrcE=1 with lwStall true -> FlushD=FlushE=1, StallF=0.
REQ-033 MemReqM=1 with MemReadyM low for 3 cycles, then high -> all four stalls high 3 cycles, FSM back to IDLE, BusTimeout=0.
REQ-034 MemReqM=1 with MemReadyM held low -> after 256 WAIT cycles, ABORT for 1 cycle with stalls 0, and BusTimeout=1 until rst pulse.
REQ-035 rst pulse mid-WAIT at WaitCnt=40 -> FSM IDLE, WaitCnt=0 and BusTimeout=0 immediately; with HAZ_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and data-bus stalls,
// branch flushes, and a data-bus wait watchdog. Optional counters: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [1:0] ResultSrcE,
    input  logic       PCSrcE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       BusTimeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] StallCycCnt,
    output logic [31:0] FlushCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ABORT = 2'd2
    } waitState_t;

    waitState_t state_q;
    logic [7:0] waitCnt_q;
    logic       busTimeout_q;
    logic       lwStall;
    logic       memStall;

    // The newest producer (Memory) wins over the older one (Writeback).
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            ForwardBE = 2'b01;
        end
    end

    assign lwStall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign memStall = MemReqM && !MemReadyM && (state_q != ABORT);

    // A bus stall freezes everything and must not flush, since a flush would
    // override the stall inside the stage registers and lose the access.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (memStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (lwStall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            waitCnt_q    <= 8'd0;
            busTimeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    waitCnt_q <= 8'd0;
                    if (memStall) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (MemReadyM) begin
                        state_q   <= IDLE;
                        waitCnt_q <= 8'd0;
                    end else if (waitCnt_q == 8'hFF) begin
                        state_q      <= ABORT;
                        busTimeout_q <= 1'b1;
                    end else begin
                        waitCnt_q <= waitCnt_q + 8'd1;
                    end
                end
                ABORT: begin
                    state_q   <= IDLE;
                    waitCnt_q <= 8'd0;
                end
                default: begin
                    state_q   <= IDLE;
                    waitCnt_q <= 8'd0;
                end
            endcase
        end
    end

    assign BusTimeout = busTimeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stallCyc_q;
    logic [31:0] flushCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCyc_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            if (StallF) begin
                stallCyc_q <= stallCyc_q + 32'd1;
            end
            if (FlushE) begin
                flushCnt_q <= flushCnt_q + 32'd1;
            end
        end
    end

    assign StallCycCnt = stallCyc_q;
    assign FlushCnt    = flushCnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a cycle-count
// reference model; builds with or without HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
    logic [1:0] ResultSrcE = '0;
    logic       PCSrcE = 1'b0;
    logic [4:0] RdM = '0, RdW = '0;
    logic       RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic       MemReqM = 1'b0, MemReadyM = 1'b1;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       BusTimeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] StallCycCnt, FlushCnt;
`endif

    int errCount = 0;
    int checkCount = 0;

    // Reference model: a wait is remembered by the cycle it started, an abort
    // by the cycle in which it happens.
    int          cycleNo = 0;
    int          waitStart = -1;
    int          abortCycle = -1;
    bit          expTimeout = 1'b0;
    bit          expMemStall;
    logic [1:0]  expFwdA, expFwdB;
    logic [3:0]  expStall;
    logic [1:0]  expFlush;
    logic [31:0] expStallCyc = '0;
    logic [31:0] expFlushCnt = '0;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .BusTimeout(BusTimeout)
`ifdef HAZ_PERF_CNT_EN
        , .StallCycCnt(StallCycCnt), .FlushCnt(FlushCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdFor(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic resetModel();
        waitStart   = -1;
        abortCycle  = -1;
        expTimeout  = 1'b0;
        expStallCyc = '0;
        expFlushCnt = '0;
    endtask

    // Expected outputs for the inputs currently applied; stall is {F,D,E,M}, flush {D,E}.
    task automatic computeExpected();
        bit lw;
        expFwdA = fwdFor(Rs1E);
        expFwdB = fwdFor(Rs2E);
        lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        expMemStall = MemReqM && !MemReadyM && (cycleNo != abortCycle);
        expStall = 4'b0000;
        expFlush = 2'b00;
        if (expMemStall) expStall = 4'b1111;
        else if (PCSrcE) expFlush = 2'b11;
        else if (lw) begin
            expStall = 4'b1100;
            expFlush = 2'b01;
        end
    endtask

    task automatic checkAll();
        computeExpected();
        checkOutput("fwdA", 32'(ForwardAE), 32'(expFwdA));
        checkOutput("fwdB", 32'(ForwardBE), 32'(expFwdB));
        checkOutput("stalls", 32'({StallF, StallD, StallE, StallM}), 32'(expStall));
        checkOutput("flushes", 32'({FlushD, FlushE}), 32'(expFlush));
        checkOutput("busTimeout", 32'(BusTimeout), 32'(expTimeout));
`ifdef HAZ_PERF_CNT_EN
        checkOutput("stallCycCnt", StallCycCnt, expStallCyc);
        checkOutput("flushCnt", FlushCnt, expFlushCnt);
`endif
    endtask

    // Clock edge: a wait lasts until ready or 256 waiting cycles, then one abort cycle.
    task automatic advanceModel();
        if (rst) begin
            resetModel();
        end else begin
            if (expStall[3]) expStallCyc = expStallCyc + 32'd1;
            if (expFlush[0]) expFlushCnt = expFlushCnt + 32'd1;
            if (cycleNo == abortCycle) begin
                waitStart = -1;
            end else if (waitStart >= 0) begin
                if (MemReadyM) waitStart = -1;
                else if (cycleNo - waitStart == 255) begin
                    abortCycle = cycleNo + 1;
                    expTimeout = 1'b1;
                    waitStart  = -1;
                end
            end else if (expMemStall) begin
                waitStart = cycleNo + 1;
            end
            cycleNo++;
        end
    endtask

    task automatic applyStimulus(input bit doRst, input bit req, input bit ready);
        rst        = doRst;
        MemReqM    = req;
        MemReadyM  = ready;
        Rs1D       = 5'($urandom_range(0, 3));
        Rs2D       = 5'($urandom_range(0, 3));
        Rs1E       = 5'($urandom_range(0, 3));
        Rs2E       = 5'($urandom_range(0, 3));
        RdE        = 5'($urandom_range(0, 3));
        RdM        = 5'($urandom_range(0, 3));
        RdW        = 5'($urandom_range(0, 3));
        ResultSrcE = 2'($urandom_range(0, 3));
        RegWriteM  = 1'($urandom_range(0, 1));
        RegWriteW  = 1'($urandom_range(0, 1));
        PCSrcE     = ($urandom_range(0, 3) == 0);
    endtask

    // Called just after a rising edge; checks at the falling edge, then advances.
    task automatic finishCycle();
        if (rst) resetModel();
        #4;
        checkAll();
        @(posedge clk);
        advanceModel();
        #1;
    endtask

    initial begin
        int stallSeen;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("resetBusTimeout", 32'(BusTimeout), 32'd0);
        finishCycle();

        // Forwarding priority example.
        applyStimulus(1'b0, 1'b0, 1'b1);
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 checkOutput("fwdFromMem", 32'(ForwardAE), 32'h2);
        RdM = 0;
        #1 checkOutput("fwdFromWb", 32'(ForwardAE), 32'h1);
        finishCycle();

        // Load-use bubble, then branch over a load-use.
        applyStimulus(1'b0, 1'b0, 1'b1);
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 0; PCSrcE = 0;
        #1 checkOutput("loadUse", 32'({StallF, StallD, FlushE, StallE, StallM}), 32'b11100);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        ResultSrcE = 2'b01; RdE = 8; Rs1D = 1; Rs2D = 2; PCSrcE = 0;
        #1 checkOutput("loadUseGone", 32'({StallF, StallD, FlushE}), 32'b000);
        finishCycle();
        applyStimulus(1'b0, 1'b0, 1'b1);
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
        #1 checkOutput("branchWins", 32'({FlushD, FlushE, StallF}), 32'b110);
        finishCycle();

        // Short bus wait: three stalled cycles then ready.
        stallSeen = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, i == 3);
            #1 stallSeen += int'(StallF && StallM);
            finishCycle();
        end
        checkOutput("shortWaitStalls", 32'(stallSeen), 32'd3);
        checkOutput("shortWaitNoTimeout", 32'(BusTimeout), 32'd0);

        // Bus never ready: one idle cycle plus 256 waiting cycles, then an abort.
        stallSeen = 0;
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            #1 stallSeen += int'(StallF);
            if (i == 257) checkOutput("abortNoStall", 32'(StallF), 32'd0);
            finishCycle();
        end
        checkOutput("timeoutStallCycles", 32'(stallSeen), 32'd257);
        checkOutput("timeoutSticky", 32'(BusTimeout), 32'd1);

        // Fresh access after abort, then reset 40 cycles into its wait.
        for (int i = 0; i < 41; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            finishCycle();
        end
        checkOutput("timeoutStillHeld", 32'(BusTimeout), 32'd1);
        rst = 1'b1;
        #1 checkOutput("asyncResetClears", 32'(BusTimeout), 32'd0);
        resetModel();
        finishCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            finishCycle();
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) != 0);
            finishCycle();
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
